// File: rtl/lm80c_mem_mapper_pkg.sv
// Shared types and address-decode helpers for the LM80C ROM/RAM mapper.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package lm80c_mem_pkg;

    typedef enum logic [1:0] {
        ER_IDLE,
        ER_RAM_CLR,
        ER_ROM_CLR,
        ER_DONE
    } erase_state_t;

    // Queued CPU write. The address is already reduced to the RAM index width.
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wq_entry_t;

    // True when a lies in [0, 2**aw).
    function automatic logic addr_below(input logic [31:0] a, input int aw);
        return (a >> aw) == 32'd0;
    endfunction

    // True when a lies in [base, base + 2**aw).
    function automatic logic in_window(input logic [31:0] a, input logic [31:0] base,
                                       input int aw);
        return (a >= base) && (((a - base) >> aw) == 32'd0);
    endfunction

endpackage

// File: rtl/lm80c_mem_mapper_if.sv
// CPU, downloader and eraser-control signals of the LM80C memory mapper.
// Latency: none (wiring only).
// Backpressure: cpu_wait from the mapper stalls the CPU side.
interface lm80c_mem_mapper_if #(parameter int LOAD_AW = 25);
    logic               rom_enable;
    logic [15:0]        cpu_addr;
    logic [7:0]         cpu_dout;
    logic               cpu_rd;
    logic               cpu_wr;
    logic [7:0]         cpu_din;
    logic               cpu_wait;
    logic               dl_active;
    logic               dl_wr;
    logic [LOAD_AW-1:0] dl_addr;
    logic [7:0]         dl_data;
    logic               erase_trig;
    logic               erase_ena;
    logic               erase_busy;

    modport slave (
        input  rom_enable, cpu_addr, cpu_dout, cpu_rd, cpu_wr,
        input  dl_active, dl_wr, dl_addr, dl_data, erase_trig, erase_ena,
        output cpu_din, cpu_wait, erase_busy
    );

    modport master (
        output rom_enable, cpu_addr, cpu_dout, cpu_rd, cpu_wr,
        output dl_active, dl_wr, dl_addr, dl_data, erase_trig, erase_ena,
        input  cpu_din, cpu_wait, erase_busy
    );
endinterface

// File: rtl/lm80c_mem_mapper_wr_queue.sv
// CPU write FIFO with full/empty flags and youngest-match address lookup.
// Latency: pushed entry visible at head and to lookup the cycle after push.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module lm80c_wr_queue
    import lm80c_mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_push,
    input  wq_entry_t   i_push_ent,
    input  logic        i_pop,
    output wq_entry_t   o_head,
    output logic        o_empty,
    output logic        o_full,
    input  logic [15:0] i_lk_addr,
    output logic        o_hit,
    output logic [7:0]  o_hit_dat
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wq_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] w_idx;
    logic          w_pop_ok;
    logic          w_push_ok;

    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == CW'(DEPTH));
    assign o_head    = r_mem[r_rptr];
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // Entry storage; contents need no reset because r_cnt gates validity.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wptr] <= i_push_ent;
    end

    // Pointers and occupancy; reset flushes every pending write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
            if (w_push_ok && !w_pop_ok)      r_cnt <= r_cnt + 1'b1;
            else if (w_pop_ok && !w_push_ok) r_cnt <= r_cnt - 1'b1;
        end
    end

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        o_hit     = 1'b0;
        o_hit_dat = '0;
        w_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rptr + PW'(i);
            if ((CW'(i) < r_cnt) && (r_mem[w_idx].addr == i_lk_addr)) begin
                o_hit     = 1'b1;
                o_hit_dat = r_mem[w_idx].data;
            end
        end
    end
endmodule

// File: rtl/lm80c_mem_mapper.sv
// ROM/RAM mapper for the LM80C: ROM overlay reads, downloader/eraser/CPU write arbitration.
// Latency: cpu_din valid 1 cycle after cpu_rd; a bypassed CPU write lands in RAM 1 cycle later.
// Backpressure: cpu_wait high while the CPU write queue is full.
module lm80c_mem_mapper
    import lm80c_mem_pkg::*;
#(
    parameter int          ROM_AW        = 15,
    parameter int          RAM_AW        = 16,
    parameter int          LOAD_AW       = 25,
    parameter int unsigned RAM_LOAD_BASE = 32'h10000,
    parameter int          WQ_DEPTH      = 2,
    parameter bit          ERASE_ROM     = 1'b0,
    parameter logic [7:0]  ERASE_FILL    = 8'h00
) (
    input logic           clk_sys,
    input logic           reset_n,
    lm80c_mem_mapper_if.slave bus
);
    localparam int CNT_W = (ROM_AW > RAM_AW) ? ROM_AW : RAM_AW;

    logic [7:0]         r_rom [2**ROM_AW];
    logic [7:0]         r_ram [2**RAM_AW];

    erase_state_t       r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_trig_q;
    logic               r_rd_rom;
    logic               r_fwd_hit;
    logic [7:0]         r_fwd_dat;
    logic [7:0]         r_rom_q;
    logic [7:0]         r_ram_q;

    logic [LOAD_AW-1:0] w_dl_addr;
    logic               w_rom_sel;
    logic               w_dl_rom_we;
    logic               w_dl_ram_we;
    logic               w_er_busy;
    logic               w_er_ram_we;
    logic               w_er_rom_we;
    logic               w_port_free;
    logic               w_wr_acc;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;
    logic               w_q_empty;
    logic               w_q_full;
    logic               w_hit;
    logic [7:0]         w_hit_dat;
    logic [15:0]        w_cpu_ram_addr;
    wq_entry_t          w_q_head;
    logic               w_ram_we;
    logic [RAM_AW-1:0]  w_ram_addr;
    logic [7:0]         w_ram_dat;
    logic               w_rom_we;
    logic [ROM_AW-1:0]  w_rom_addr;
    logic [7:0]         w_rom_dat;

    assign w_dl_addr      = bus.dl_addr;
    assign w_rom_sel      = bus.rom_enable && addr_below({16'h0, bus.cpu_addr}, ROM_AW);
    assign w_dl_rom_we    = bus.dl_wr && addr_below(32'(w_dl_addr), ROM_AW);
    assign w_dl_ram_we    = bus.dl_wr && in_window(32'(w_dl_addr), RAM_LOAD_BASE, RAM_AW);
    assign w_cpu_ram_addr = 16'(bus.cpu_addr[RAM_AW-1:0]);

    // Eraser yields to the downloader: frozen for the whole session, and never loses a slot.
    assign w_er_busy   = (r_state != ER_IDLE);
    assign w_er_ram_we = (r_state == ER_RAM_CLR) && bus.erase_ena && !bus.dl_active && !w_dl_ram_we;
    assign w_er_rom_we = (r_state == ER_ROM_CLR) && bus.erase_ena && !bus.dl_active && !w_dl_rom_we;

    // CPU writes under the ROM overlay are dropped; others bypass only into an empty queue.
    assign w_port_free = !w_dl_ram_we && !w_er_busy;
    assign w_wr_acc    = bus.cpu_wr && !w_rom_sel;
    assign w_bypass    = w_wr_acc && w_q_empty && w_port_free;
    assign w_push      = w_wr_acc && !w_bypass;
    assign w_pop       = !w_q_empty && w_port_free;

    lm80c_wr_queue #(.DEPTH(WQ_DEPTH)) u_wq (
        .i_clk      (clk_sys),
        .i_rst_n    (reset_n),
        .i_push     (w_push),
        .i_push_ent ('{addr: w_cpu_ram_addr, data: bus.cpu_dout}),
        .i_pop      (w_pop),
        .o_head     (w_q_head),
        .o_empty    (w_q_empty),
        .o_full     (w_q_full),
        .i_lk_addr  (w_cpu_ram_addr),
        .o_hit      (w_hit),
        .o_hit_dat  (w_hit_dat)
    );

    assign bus.cpu_wait   = w_q_full;
    assign bus.erase_busy = w_er_busy;
    assign bus.cpu_din    = r_rd_rom ? r_rom_q : (r_fwd_hit ? r_fwd_dat : r_ram_q);

    // Per-memory write port mux: downloader, then eraser, then queue drain / bypass.
    always_comb begin
        w_ram_we   = 1'b0;
        w_ram_addr = '0;
        w_ram_dat  = '0;
        w_rom_we   = 1'b0;
        w_rom_addr = '0;
        w_rom_dat  = '0;
        if (w_dl_ram_we) begin
            w_ram_we   = 1'b1;
            w_ram_addr = RAM_AW'(32'(w_dl_addr) - RAM_LOAD_BASE);
            w_ram_dat  = bus.dl_data;
        end else if (w_er_ram_we) begin
            w_ram_we   = 1'b1;
            w_ram_addr = r_cnt[RAM_AW-1:0];
            w_ram_dat  = ERASE_FILL;
        end else if (w_pop) begin
            w_ram_we   = 1'b1;
            w_ram_addr = w_q_head.addr[RAM_AW-1:0];
            w_ram_dat  = w_q_head.data;
        end else if (w_bypass) begin
            w_ram_we   = 1'b1;
            w_ram_addr = bus.cpu_addr[RAM_AW-1:0];
            w_ram_dat  = bus.cpu_dout;
        end
        if (w_dl_rom_we) begin
            w_rom_we   = 1'b1;
            w_rom_addr = w_dl_addr[ROM_AW-1:0];
            w_rom_dat  = bus.dl_data;
        end else if (w_er_rom_we) begin
            w_rom_we   = 1'b1;
            w_rom_addr = r_cnt[ROM_AW-1:0];
            w_rom_dat  = ERASE_FILL;
        end
    end

    // Memory arrays; no reset so contents survive a reset pulse.
    always_ff @(posedge clk_sys) begin
        if (w_ram_we) r_ram[w_ram_addr] <= w_ram_dat;
        if (w_rom_we) r_rom[w_rom_addr] <= w_rom_dat;
    end

    // Read pipeline: source select and queue forwarding captured with the address.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_rom  <= 1'b0;
            r_fwd_hit <= 1'b0;
            r_fwd_dat <= '0;
            r_rom_q   <= '0;
            r_ram_q   <= '0;
        end else if (bus.cpu_rd) begin
            r_rd_rom  <= w_rom_sel;
            r_fwd_hit <= w_hit;
            r_fwd_dat <= w_hit_dat;
            r_rom_q   <= r_rom[bus.cpu_addr[ROM_AW-1:0]];
            r_ram_q   <= r_ram[bus.cpu_addr[RAM_AW-1:0]];
        end
    end

    // Eraser FSM: one fill write per enabled slot, single-cycle DONE before returning idle.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ER_IDLE;
            r_cnt    <= '0;
            r_trig_q <= 1'b0;
        end else begin
            r_trig_q <= bus.erase_trig;
            case (r_state)
                ER_IDLE: begin
                    if (bus.erase_trig && !r_trig_q) begin
                        r_state <= ER_RAM_CLR;
                        r_cnt   <= '0;
                    end
                end
                ER_RAM_CLR: begin
                    if (w_er_ram_we) begin
                        if (r_cnt == CNT_W'((1 << RAM_AW) - 1)) begin
                            r_cnt   <= '0;
                            r_state <= ERASE_ROM ? ER_ROM_CLR : ER_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ER_ROM_CLR: begin
                    if (w_er_rom_we) begin
                        if (r_cnt == CNT_W'((1 << ROM_AW) - 1)) begin
                            r_cnt   <= '0;
                            r_state <= ER_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ER_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lm80c_mem_mapper.sv
// Directed bench for lm80c_mem_mapper with reduced memories (ROM 256 B, RAM 4 KiB).
// Latency: reads checked one cycle after the read strobe.
// Backpressure: writes issued only while cpu_wait is low.
module tb_lm80c_mem_mapper;
    localparam int          ROM_AW = 8;
    localparam int          RAM_AW = 12;
    localparam int unsigned BASE   = 32'h10000;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;
    int   n;
    int   bad;
    logic [7:0] d;

    lm80c_mem_mapper_if #(.LOAD_AW(25)) bus ();

    lm80c_mem_mapper #(
        .ROM_AW(ROM_AW), .RAM_AW(RAM_AW), .LOAD_AW(25), .RAM_LOAD_BASE(BASE),
        .WQ_DEPTH(2), .ERASE_ROM(1'b0), .ERASE_FILL(8'h00)
    ) dut (
        .clk_sys (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] v);
        check("wr_not_full", {31'd0, bus.cpu_wait}, 32'd0);
        bus.cpu_addr = a;
        bus.cpu_dout = v;
        bus.cpu_wr   = 1'b1;
        step();
        bus.cpu_wr   = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] v);
        bus.cpu_addr = a;
        bus.cpu_rd   = 1'b1;
        step();
        bus.cpu_rd   = 1'b0;
        v = bus.cpu_din;
    endtask

    task automatic check_rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
        logic [7:0] v;
        cpu_read(a, v);
        check(tag, {24'd0, v}, {24'd0, exp});
    endtask

    task automatic dl_write(input logic [24:0] a, input logic [7:0] v);
        bus.dl_addr = a;
        bus.dl_data = v;
        bus.dl_wr   = 1'b1;
        step();
        bus.dl_wr   = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        bus.rom_enable = 1'b0; bus.cpu_addr = '0; bus.cpu_dout = '0;
        bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.dl_active = 1'b0; bus.dl_wr = 1'b0;
        bus.dl_addr = '0; bus.dl_data = '0; bus.erase_trig = 1'b0; bus.erase_ena = 1'b1;
        repeat (3) step();
        check("rst_din",  {24'd0, bus.cpu_din}, 32'd0);
        check("rst_wait", {31'd0, bus.cpu_wait}, 32'd0);
        check("rst_busy", {31'd0, bus.erase_busy}, 32'd0);
        rst_n = 1'b1;
        step();

        // 1: ROM image download, overlay reads
        bus.dl_active = 1'b1;
        for (int i = 0; i < 256; i++) dl_write(25'(i), 8'(i));
        bus.dl_active = 1'b0;
        bus.rom_enable = 1'b1;
        step();
        check_rd("t1_rom_10", 16'h0010, 8'h10);
        check_rd("t1_rom_ff", 16'h00FF, 8'hFF);

        // 2: overlay write protection and window edge
        cpu_write(16'h0010, 8'hAA);
        check_rd("t2_rom_prot", 16'h0010, 8'h10);
        cpu_write(16'h0100, 8'h3C);
        check_rd("t2_edge_ram", 16'h0100, 8'h3C);
        bus.rom_enable = 1'b0;
        cpu_write(16'h0010, 8'hAA);
        check_rd("t2_ram_wr", 16'h0010, 8'hAA);

        // 3: queueing while the downloader owns the RAM port
        bus.dl_active = 1'b1; bus.dl_wr = 1'b1;
        bus.dl_addr = 25'(BASE + 32'h800); bus.dl_data = 8'h77;
        cpu_write(16'h9000, 8'h11);
        check("t3_wait_1st", {31'd0, bus.cpu_wait}, 32'd0);
        cpu_write(16'h9001, 8'h22);
        check("t3_wait_full", {31'd0, bus.cpu_wait}, 32'd1);
        check_rd("t3_fwd_9001", 16'h9001, 8'h22);
        check_rd("t3_fwd_9000", 16'h9000, 8'h11);
        bus.dl_wr = 1'b0; bus.dl_active = 1'b0;
        step(); step();
        check("t3_drained", {31'd0, bus.cpu_wait}, 32'd0);
        cpu_write(16'h9002, 8'h33);
        check_rd("t3_ram_9000", 16'h9000, 8'h11);
        check_rd("t3_ram_9001", 16'h9001, 8'h22);
        check_rd("t3_ram_9002", 16'h9002, 8'h33);
        bus.dl_active = 1'b1; bus.dl_wr = 1'b1;
        cpu_write(16'h9005, 8'h44);
        cpu_write(16'h9005, 8'h55);
        check_rd("t3_youngest", 16'h9005, 8'h55);
        bus.dl_wr = 1'b0; bus.dl_active = 1'b0;
        step(); step();
        check_rd("t3_youngest_ram", 16'h9005, 8'h55);

        // 4: full RAM erase, retrigger while busy ignored
        bus.erase_trig = 1'b1; step(); bus.erase_trig = 1'b0;
        n = 0;
        while (bus.erase_busy && n < 20000) begin
            n++;
            if (n == 10) bus.erase_trig = 1'b1;
            if (n == 11) bus.erase_trig = 1'b0;
            step();
        end
        check("t4_busy_cycles", n, 32'd4097);
        repeat (5) step();
        check("t4_no_retrig", {31'd0, bus.erase_busy}, 32'd0);
        check_rd("t4_ram_0010", 16'h0010, 8'h00);
        check_rd("t4_ram_9001", 16'h9001, 8'h00);
        check_rd("t4_ram_last", 16'h0FFF, 8'h00);
        bus.rom_enable = 1'b1;
        check_rd("t4_rom_10", 16'h0010, 8'h10);
        check_rd("t4_rom_ff", 16'h00FF, 8'hFF);

        // 5: prefill, stray downloader addresses, erase paused by downloader
        bus.rom_enable = 1'b0;
        bus.dl_active = 1'b1;
        for (int i = 0; i < 4096; i++) dl_write(25'(BASE + 32'(i)), 8'h80 | 8'(i & 'h7F));
        dl_write(25'h11000, 8'hEE);
        dl_write(25'h00100, 8'hEE);
        bus.dl_active = 1'b0;
        check_rd("t5_prefill", 16'h0ABC, 8'hBC);
        check_rd("t5_stray_ram", 16'h0000, 8'h80);
        bus.rom_enable = 1'b1;
        check_rd("t5_stray_rom", 16'h0000, 8'h00);
        bus.rom_enable = 1'b0;
        bus.erase_trig = 1'b1; step(); bus.erase_trig = 1'b0;
        n = 0;
        while (bus.erase_busy && n < 20000) begin
            n++;
            if (n == 50)  bus.dl_active = 1'b1;
            if (n == 150) bus.dl_active = 1'b0;
            step();
        end
        check("t5_busy_paused", n, 32'd4197);
        bad = 0;
        for (int i = 0; i < 4096; i++) begin
            cpu_read(16'(i), d);
            if (d !== 8'h00) bad++;
        end
        check("t5_all_zero", bad, 32'd0);

        // 6: reset mid-erase with two queued writes
        dl_write(25'(BASE + 32'hF00), 8'h5A);
        dl_write(25'(BASE + 32'hF01), 8'h5B);
        bus.erase_trig = 1'b1; step(); bus.erase_trig = 1'b0;
        repeat (2048) step();
        check("t6_busy", {31'd0, bus.erase_busy}, 32'd1);
        cpu_write(16'h0F00, 8'hC1);
        cpu_write(16'h0F01, 8'hC2);
        check("t6_wait_full", {31'd0, bus.cpu_wait}, 32'd1);
        check_rd("t6_fwd", 16'h0F00, 8'hC1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_din",  {24'd0, bus.cpu_din}, 32'd0);
        check("t6_rst_wait", {31'd0, bus.cpu_wait}, 32'd0);
        check("t6_rst_busy", {31'd0, bus.erase_busy}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check_rd("t6_lost_f00", 16'h0F00, 8'h5A);
        check_rd("t6_lost_f01", 16'h0F01, 8'h5B);
        check_rd("t6_erased_0", 16'h0000, 8'h00);
        cpu_write(16'h0F00, 8'h66);
        check_rd("t6_post_wr", 16'h0F00, 8'h66);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
